// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 2**AW-entry register file with bypassed read ports, debug port and write counter
module wb_regfile #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RFWEW,
  input  logic            MtoRFSelW,
  input  logic [DW-1:0]   ALUOutW,
  input  logic [DW-1:0]   DMOutW,
  input  logic [AW-1:0]   RFAW,
  input  logic [AW-1:0]   RFRA1,
  input  logic [AW-1:0]   RFRA2,
  input  logic [AW-1:0]   DbgRA,
  output logic [DW-1:0]   RFWD,
  output logic [DW-1:0]   RFRD1,
  output logic [DW-1:0]   RFRD2,
  output logic [DW-1:0]   DbgRD,
  output logic [CNTW-1:0] WrCnt,
  output logic [AW-1:0]   LastWA
);
  localparam int N = 2 ** AW;
  logic [DW-1:0]   regs_q [N];
  logic [DW-1:0]   regs_d [N];
  logic [CNTW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   last_wa_q, last_wa_d;
  logic            commit;
  logic            byp1, byp2;
  assign RFWD   = MtoRFSelW ? DMOutW : ALUOutW;
  // RFWEW is tested first so an unknown address with the enable low cannot commit
  assign commit = RFWEW && (RFAW != '0);
  assign byp1   = RFWEW && (RFAW == RFRA1);
  assign byp2   = RFWEW && (RFAW == RFRA2);
  assign RFRD1  = (RFRA1 == '0) ? '0 : byp1 ? RFWD : regs_q[RFRA1];
  assign RFRD2  = (RFRA2 == '0) ? '0 : byp2 ? RFWD : regs_q[RFRA2];
  assign DbgRD  = (DbgRA == '0) ? '0 : regs_q[DbgRA];
  assign WrCnt  = wr_cnt_q;
  assign LastWA = last_wa_q;
  // next state: a committed write updates one entry, bumps the counter and records the address
  always_comb begin
    regs_d    = regs_q;
    wr_cnt_d  = wr_cnt_q;
    last_wa_d = last_wa_q;
    if (commit) begin
      regs_d[RFAW] = RFWD;
      wr_cnt_d     = wr_cnt_q + CNTW'(1);
      last_wa_d    = RFAW;
    end
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      wr_cnt_q  <= '0;
      last_wa_q <= '0;
    end else begin
      regs_q    <= regs_d;
      wr_cnt_q  <= wr_cnt_d;
      last_wa_q <= last_wa_d;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized scoreboard bench for wb_regfile against an array-based reference model
module tb_wb_regfile;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        RFWEW = 0, MtoRFSelW = 0;
  logic [31:0] ALUOutW = 0, DMOutW = 0;
  logic [4:0]  RFAW = 0, RFRA1 = 0, RFRA2 = 0, DbgRA = 0;
  logic [31:0] RFWD, RFRD1, RFRD2, DbgRD;
  logic [3:0]  WrCnt;
  logic [4:0]  LastWA;

  wb_regfile #(.DW(32), .AW(5), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .RFWEW(RFWEW), .MtoRFSelW(MtoRFSelW),
    .ALUOutW(ALUOutW), .DMOutW(DMOutW), .RFAW(RFAW), .RFRA1(RFRA1),
    .RFRA2(RFRA2), .DbgRA(DbgRA), .RFWD(RFWD), .RFRD1(RFRD1),
    .RFRD2(RFRD2), .DbgRD(DbgRD), .WrCnt(WrCnt), .LastWA(LastWA)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wd, rd1, rd2, dbg;
    logic [3:0]  cnt;
    logic [4:0]  lwa;
    bit          chk_wd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mdl [32];
  logic [3:0]  cnt;
  logic [4:0]  lwa;

  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  // monitor: each sampled cycle pops one expectation and compares every output
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk_wd) cmp("RFWD", RFWD, e.wd);
      cmp("RFRD1", RFRD1, e.rd1);
      cmp("RFRD2", RFRD2, e.rd2);
      cmp("DbgRD", DbgRD, e.dbg);
      cmp("WrCnt", {28'b0, WrCnt}, {28'b0, e.cnt});
      cmp("LastWA", {27'b0, LastWA}, {27'b0, e.lwa});
    end
  end

  function automatic logic [31:0] mrd(input logic [4:0] ra, input logic we,
                                      input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 0) return 0;
    if (we && wa == ra) return wd;
    return mdl[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    cnt = 0;
    lwa = 0;
  endtask

  task automatic drive(input logic we, input logic sel, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [4:0] wa, input logic [4:0] ra1,
                       input logic [4:0] ra2, input logic [4:0] dra, input bit chkwd = 1);
    exp_t        e;
    logic [31:0] wd;
    @(posedge clk);
    #1;
    RFWEW = we; MtoRFSelW = sel; ALUOutW = alu; DMOutW = dm;
    RFAW = wa; RFRA1 = ra1; RFRA2 = ra2; DbgRA = dra;
    wd = sel ? dm : alu;
    e.wd = wd; e.chk_wd = chkwd;
    e.rd1 = mrd(ra1, we, wa, wd);
    e.rd2 = mrd(ra2, we, wa, wd);
    e.dbg = mdl[dra];
    e.cnt = cnt; e.lwa = lwa;
    q.push_back(e);
    if (rst_n && we && wa != 0) begin
      mdl[wa] = wd;
      cnt = cnt + 4'd1;
      lwa = wa;
    end
  endtask

  task automatic rand_cycle();
    logic [4:0] wa, r1, r2;
    wa = 5'($urandom_range(0, 31));
    r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
    r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
    drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
          wa, r1, r2, 5'($urandom_range(0, 31)));
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31, 5'd7);
    @(negedge clk);
    #1 rst_n = 1;
    drive(1, 0, 32'h0000_1234, 32'h0, 5'd5, 5'd1, 5'd2, 5'd5);
    drive(1, 1, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0, 5'd5);
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5, 5'd5);
    drive(1, 0, 32'h0000_0077, 32'h0, 5'd7, 5'd0, 5'd0, 5'd7);
    drive(1, 0, 32'hA5A5_A5A5, 32'h0, 5'd7, 5'd7, 5'd7, 5'd7);
    drive(1, 0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd7, 5'd7);
    drive(1, 0, 32'h0000_0333, 32'h0, 5'd3, 5'd3, 5'd0, 5'd0);
    drive(0, 0, 32'h1111_1111, 32'h0, 5'd3, 5'd3, 5'd3, 5'd3);
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0, 5'd3);
    drive(0, 1'bx, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 5'bxxxxx, 5'd5, 5'd7, 5'd3, 0);
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7, 5'd3);
    for (int i = 0; i < 150; i++) rand_cycle();
    // asynchronous reset mid-cycle while a write to r9 is presented; bypass still visible
    @(posedge clk);
    #1;
    RFWEW = 1; MtoRFSelW = 0; ALUOutW = 32'h9999_0009; RFAW = 5'd9;
    RFRA1 = 5'd9; RFRA2 = 5'd4; DbgRA = 5'd9;
    #2 rst_n = 0;
    model_clear();
    begin
      exp_t e;
      e.wd = 32'h9999_0009; e.chk_wd = 1; e.rd1 = 32'h9999_0009;
      e.rd2 = 0; e.dbg = 0; e.cnt = 0; e.lwa = 0;
      q.push_back(e);
    end
    drive(1, 1, 32'h0, 32'hCAFE_0009, 5'd9, 5'd9, 5'd9, 5'd9);
    @(posedge clk);
    #1 RFWEW = 0;
    rst_n = 1;
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd4, 5'd9);
    for (int i = 0; i < 17; i++)
      drive(1, 0, 32'h100 + 32'(i), 32'h0, 5'((i % 31) + 1), 5'((i % 31) + 1), 5'd1, 5'd1);
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd17, 5'd16, 5'd17);
    for (int i = 0; i < 150; i++) rand_cycle();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain act=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
